serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
Bit-serial subtract controller. It sequences a single one-bit full-subtractor cell over a WIDTH-bit operand pair, LSB first, one bit per clock. It computes diff = a - b - bor_in and the final borrow. It sits between a requester using a start/done handshake and the shared gate-level subtractor cell, trading latency for area in the team's arithmetic datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.
CNT_W, $clog2(WIDTH) (minimum 1), bit-counter width; derived, not overridden.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous and active-low.
start  input  1  request; sampled only when ready=1.
a  input  WIDTH  minuend; captured on the accepting edge.
b  input  WIDTH  subtrahend; captured on the accepting edge.
bor_in  input  1  initial borrow into bit 0; captured on the accepting edge.
ready  output  1  high in IDLE only.
busy  output  1  high in RUN only.
done  output  1  one-cycle pulse; result valid.
diff  output  WIDTH  difference; held until the next accepted start.
bor_out  output  1  final borrow (1 => a < b + bor_in, unsigned); held with diff.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, ready=1, busy=0, done=0, diff=0, bor_out=0, counter=0, shift registers=0. Deassertion is synchronous to clk (2-flop synchroniser is outside this block).
- FSM states: IDLE, RUN, DONE. Encoding is 2-bit binary: IDLE=0, RUN=1, DONE=2. Unused code 3 returns to IDLE.
- IDLE: on an edge with start=1:
  - load a_sh<=a, b_sh<=b, borrow<=bor_in, cnt<=0;
  - go to RUN.
  - start=0 stays in IDLE.
- RUN: each edge does the following:
  - cell inputs are a_sh[0], b_sh[0] and borrow;
  - cell diff bit shifts into the MSB of the result register (right shift);
  - borrow<=cell bor_out; a_sh and b_sh shift right by 1; cnt<=cnt+1.
  - When cnt==WIDTH-1 on an edge: that edge processes the last bit, bor_out<=cell bor_out, and state goes to DONE.
- DONE: done=1 for exactly this cycle; diff/bor_out are valid. The next edge goes unconditionally to IDLE.
- Latency: edge E accepts start; done is high in the cycle after edge E+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start while busy or in DONE is ignored and not queued. Operand changes after acceptance have no effect.
- diff and bor_out update only at the transition into DONE. Intermediate shifting uses an internal result register, so outputs never show partial results.
- WIDTH=1: RUN lasts one edge (cnt==0==WIDTH-1).
- Reset mid-RUN: the operation is aborted, all outputs return to reset values, and no done pulse is issued.
- Arithmetic is modulo 2^WIDTH. bor_out equals the unsigned borrow, not a sign bit.

Decomposition:
- Shared include serial_arith_defs.vh holds:
  - the state encoding localparams (S_IDLE, S_RUN, S_DONE);
  - the CNT_W derivation macro, reused by a future serial adder controller.
- One sub-module: full_sub_cell. It is a combinational 1-bit subtractor with ports a, b, bor_in, diff, bor_out, where diff = a^b^bor_in and bor_out = (~a&b) | (~(a^b)&bor_in).
- The controller contains only the FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bor_in=0, start one cycle -> done exactly 8 cycles after the accept edge (+1 for DONE), diff=0x1E, bor_out=0; ready returns 1 the cycle after done.
- a=0x00, b=0x01, bor_in=0 -> diff=0xFF, bor_out=1. Also a=0x10, b=0x0F, bor_in=1 -> diff=0x00, bor_out=0.
- Pulse start=1 with a=0xFF, b=0x00 during RUN of an operation with a=0x05, b=0x07 -> second request ignored; the single done gives diff=0xFE, bor_out=1; busy never drops mid-op.
- Assert rst_n=0 for one cycle at bit 4 of a RUN -> outputs immediately 0, ready=1, no done; a fresh start then completes normally.
- Back-to-back: hold start=1 continuously with varying random operands -> a new op is accepted every WIDTH+2 cycles. diff/bor_out match a-b-bor_in (mod 256) against a scoreboard over 1000 ops, including a=b and bor_in=1 (-> 0xFF, bor_out=1).
- WIDTH=1 instance: all 8 (a,b,bor_in) combinations -> diff/bor_out match the full-subtractor truth table, with done 2 cycles after accept.

Source files
------------

// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial arithmetic controllers: state encoding
// and the bit-counter width derivation.
`ifndef SERIAL_ARITH_DEFS
`define SERIAL_ARITH_DEFS
// Counter width for a WIDTH-bit serial op; a 1-bit op still needs one counter bit.
`define SERIAL_CNT_W(w) (((w) > 1) ? $clog2(w) : 1)
`endif

package serial_sub_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } serial_state_e;

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor shared by the serial controller.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bor_in,
    output logic diff,
    output logic bor_out
);

    assign diff    = a ^ b ^ bor_in;
    assign bor_out = (~a & b) | (~(a ^ b) & bor_in);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtract controller: diff = a - b - bor_in, LSB first, one bit per
// clock through a single full_sub_cell, with a start/done handshake.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bor_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bor_out
);

    localparam int CNT_W = `SERIAL_CNT_W(WIDTH);

    serial_state_e    state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
    logic [CNT_W-1:0] cnt;
    logic             borrow;
    logic             cell_d, cell_bo;
    logic             last_bit;

    full_sub_cell u_cell (
        .a       (a_sh[0]),
        .b       (b_sh[0]),
        .bor_in  (borrow),
        .diff    (cell_d),
        .bor_out (cell_bo)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    // New bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
    assign res_nxt  = WIDTH'({cell_d, res_sh} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            diff    <= '0;
            bor_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bor_in;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_nxt;
                    borrow <= cell_bo;
                    cnt    <= cnt + CNT_W'(1);
                    // Outputs change only here so partial results never show.
                    if (last_bit) begin
                        diff    <= res_nxt;
                        bor_out <= cell_bo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, bor_in;
    logic [7:0] a, b, diff;
    logic       ready, busy, done, bor_out;

    logic       s_start, s_bin, s_ready, s_busy, s_done, s_bo;
    logic [0:0] s_a, s_b, s_diff;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bor_in(bor_in),
        .ready(ready), .busy(busy), .done(done), .diff(diff), .bor_out(bor_out)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .a(s_a), .b(s_b), .bor_in(s_bin),
        .ready(s_ready), .busy(s_busy), .done(s_done), .diff(s_diff), .bor_out(s_bo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 op with hand-computed expectations; done due 9 negedges after start.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                       input logic [7:0] ed, input logic eb, input string tag);
        int k;
        @(negedge clk);
        a = ta; b = tb_; bor_in = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        k = 1;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, k, 9);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_bor"}, bor_out, eb);
        @(negedge clk);
        chk({tag, "_rdy"}, ready, 1);
        chk({tag, "_done_low"}, done, 0);
    endtask

    task automatic op1(input logic ta, input logic tb_, input logic tc,
                       input logic ed, input logic eb, input string tag);
        int k;
        @(negedge clk);
        s_a = ta; s_b = tb_; s_bin = tc; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        k = 1;
        while (!s_done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, k, 2);
        chk({tag, "_diff"}, s_diff, ed);
        chk({tag, "_bor"}, s_bo, eb);
    endtask

    initial begin
        int         k, n, cyc, n_acc, n_done, last_acc, tmp;
        logic       drop;
        logic [7:0] ra, rb, d_tab, b_tab;
        logic       rc;
        logic [8:0] q[$];
        logic [8:0] exp9;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bor_in = 1'b0;
        s_start = 1'b0; s_a = '0; s_b = '0; s_bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bor", bor_out, 0);
        rst_n = 1'b1;

        op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "op_5a_3c");
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "op_00_01");
        op8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, "op_10_0f_b");

        // Second start during RUN must be ignored.
        @(negedge clk);
        a = 8'h05; b = 8'h07; bor_in = 1'b0; start = 1'b1;
        @(negedge clk);
        k = 1; drop = 1'b0;
        while (!done && k < 40) begin
            if (!busy) drop = 1'b1;
            if (k == 3) begin a = 8'hFF; b = 8'h00; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            k++;
        end
        chk("ign_lat", k, 9);
        chk("ign_busy_drop", drop, 0);
        chk("ign_diff", diff, 8'hFE);
        chk("ign_bor", bor_out, 1);
        n = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("ign_extra_done", n, 0);
        chk("ign_ready", ready, 1);

        // Reset at bit 4 of a RUN.
        a = 8'h33; b = 8'h11; bor_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_diff", diff, 0);
        chk("mid_rst_bor", bor_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("mid_no_done", n, 0);
        op8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, "post_rst");

        // Back-to-back with start held high against an arithmetic scoreboard.
        cyc = 0; n_acc = 0; n_done = 0; last_acc = 0;
        start = 1'b1;
        while (n_done < 1000 && cyc < 11000) begin
            if (ready) begin
                if (n_acc < 1000) begin
                    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
                    if (n_acc % 97 == 0) begin rb = ra; rc = 1'b1; end
                    a = ra; b = rb; bor_in = rc;
                    tmp = int'(ra) - int'(rb) - int'(rc);
                    q.push_back({tmp < 0, tmp[7:0]});
                    if (n_acc > 0) chk("b2b_interval", cyc - last_acc, 10);
                    last_acc = cyc;
                    n_acc++;
                end else begin
                    start = 1'b0;
                end
            end
            if (done) begin
                n_done++;
                if (q.size() == 0) chk("b2b_unexpected_done", 1, 0);
                else begin
                    exp9 = q.pop_front();
                    chk("b2b_diff", diff, exp9[7:0]);
                    chk("b2b_bor", bor_out, exp9[8]);
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("b2b_count", n_done, 1000);

        // WIDTH=1 truth table, indexed by {a,b,bor_in}.
        d_tab = 8'b1001_0110;
        b_tab = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            op1(i[2], i[1], i[0], d_tab[i], b_tab[i], $sformatf("w1_%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
